// File: rtl/clkdiv_pkg.sv
// Shared definitions for the divided-clock monitor: FSM state encoding and
// the timeout multiplier applied to the expected divide ratio.
package clkdiv_pkg;

    // Monitor FSM: waiting to arm, measuring towards lock, or locked
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    // A period longer than this many expected periods counts as a dead clock
    localparam int TIMEOUT_MULT = 2;

endpackage

// File: rtl/clk_div_monitor_if.sv
// Bundle of the monitored divided clock and the measurement results.
// The monitor drives the results (master); a consumer such as a bench or a
// status block reads them and, in a bench, drives the divided clock (slave).
interface clk_div_monitor_if #(
    parameter int CW = 8
);
    logic          clk_div;
    logic          meas_valid;
    logic [CW-1:0] period_o;
    logic [CW-1:0] high_o;
    logic          err;
    logic          locked;

    modport master (
        input  clk_div,
        output meas_valid,
        output period_o,
        output high_o,
        output err,
        output locked
    );

    modport slave (
        output clk_div,
        input  meas_valid,
        input  period_o,
        input  high_o,
        input  err,
        input  locked
    );

endinterface

// File: rtl/clkdiv_edge_det.sv
// Two-stage sampler of the divided clock in the source clock domain.
// Provides the sampled level and a one-cycle rising-edge indication.
module clkdiv_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic clk_div_i,
    output logic rise_o,
    output logic level_o
);

    logic s1_q;
    logic s2_q;

    // Sample the divided clock as data and keep one cycle of history
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= clk_div_i;
            s2_q <= s1_q;
        end
    end

    assign rise_o  = s1_q & ~s2_q;
    assign level_o = s1_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: measures period and high time of each cycle of
// clk_div in clk cycles, flags bad periods and dead clocks, and reports
// lock after LOCK_CNT consecutive good periods.
module clk_div_monitor
    import clkdiv_pkg::*;
#(
    parameter int DIV      = 9,
    parameter int HI_MIN   = 4,
    parameter int HI_MAX   = 5,
    parameter int LOCK_CNT = 4,
    parameter int CW       = 8
) (
    input  logic                clk,
    input  logic                rst,
    clk_div_monitor_if.master   mon
);

    localparam int GW = $clog2(LOCK_CNT + 1);

    localparam logic [CW-1:0] PMAX     = CW'(TIMEOUT_MULT * DIV);
    localparam logic [CW-1:0] DIV_C    = CW'(DIV);
    localparam logic [CW-1:0] HI_MIN_C = CW'(HI_MIN);
    localparam logic [CW-1:0] HI_MAX_C = CW'(HI_MAX);
    localparam logic [GW-1:0] LOCK_C   = GW'(LOCK_CNT);

    logic          rise;
    logic          level;

    state_e        state_q, state_d;
    logic [CW-1:0] pcnt_q, pcnt_d;
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [GW-1:0] good_q, good_d;
    logic [CW-1:0] period_q, period_d;
    logic [CW-1:0] high_q, high_d;
    logic          mv_q, mv_d;
    logic          err_q, err_d;
    logic          lock_q, lock_d;

    logic          measuring;
    logic          timeout;
    logic          period_good;
    logic [GW-1:0] good_inc;

    clkdiv_edge_det u_edge (
        .clk       (clk),
        .rst       (rst),
        .clk_div_i (mon.clk_div),
        .rise_o    (rise),
        .level_o   (level)
    );

    // A rise wins over a timeout on the same cycle; the period then reads 2*DIV
    assign measuring   = (state_q != IDLE);
    assign timeout     = measuring && !rise && (pcnt_q == PMAX);
    assign period_good = (pcnt_q == DIV_C) && (hcnt_q >= HI_MIN_C) && (hcnt_q <= HI_MAX_C);
    assign good_inc    = (good_q == LOCK_C) ? good_q : good_q + GW'(1);

    // Period and high-time counters restart on every rise and saturate otherwise
    always_comb begin
        pcnt_d = pcnt_q;
        hcnt_d = hcnt_q;
        if (rise) begin
            pcnt_d = CW'(1);
            hcnt_d = CW'(1);
        end else begin
            if (pcnt_q != PMAX) begin
                pcnt_d = pcnt_q + CW'(1);
            end
            if (level && (hcnt_q != PMAX)) begin
                hcnt_d = hcnt_q + CW'(1);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: arm on first rise, lock on a run of good periods, drop on errors
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    if (period_good && (good_inc == LOCK_C)) begin
                        state_d = LOCKED;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                if (rise) begin
                    if (!period_good) begin
                        state_d = MEASURE;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: measurement capture, error pulse, good-run count and lock level
    always_comb begin
        mv_d     = 1'b0;
        err_d    = 1'b0;
        period_d = period_q;
        high_d   = high_q;
        good_d   = good_q;
        lock_d   = lock_q;
        if (measuring && rise) begin
            mv_d     = 1'b1;
            period_d = pcnt_q;
            high_d   = hcnt_q;
            if (period_good) begin
                good_d = good_inc;
                if (good_inc == LOCK_C) begin
                    lock_d = 1'b1;
                end
            end else begin
                err_d  = 1'b1;
                good_d = '0;
                lock_d = 1'b0;
            end
        end else if (timeout) begin
            err_d  = 1'b1;
            good_d = '0;
            lock_d = 1'b0;
        end
    end

    // Counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q   <= '0;
            hcnt_q   <= '0;
            good_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            mv_q     <= 1'b0;
            err_q    <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            pcnt_q   <= pcnt_d;
            hcnt_q   <= hcnt_d;
            good_q   <= good_d;
            period_q <= period_d;
            high_q   <= high_d;
            mv_q     <= mv_d;
            err_q    <= err_d;
            lock_q   <= lock_d;
        end
    end

    assign mon.meas_valid = mv_q;
    assign mon.period_o   = period_q;
    assign mon.high_o     = high_q;
    assign mon.err        = err_q;
    assign mon.locked     = lock_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: the divided clock is built from (high, low)
// segments; a period-level reference model predicts each measurement or
// timeout with its output cycle, and a negedge monitor compares them.
module tb_clk_div_monitor;

    localparam int DIV      = 9;
    localparam int HI_MIN   = 4;
    localparam int HI_MAX   = 5;
    localparam int LOCK_CNT = 4;
    localparam int CW       = 8;
    localparam int TMO      = 2 * DIV;

    typedef struct {
        int cyc;
        bit mv;
        bit er;
        int per;
        int hi;
        bit lk;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t expQ[$];

    // Reference model state, at the level of whole periods
    bit pending;
    int pendP, pendH;
    int goodCnt;
    bit lockedM;
    int lastPer, lastHi;

    clk_div_monitor_if #(.CW(CW)) monIf ();

    clk_div_monitor #(
        .DIV(DIV), .HI_MIN(HI_MIN), .HI_MAX(HI_MAX), .LOCK_CNT(LOCK_CNT), .CW(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mon (monIf)
    );

    // Source clock and a free-running cycle number used for latency checks
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic checkVal(input string name, input int act, input int expv);
        checks = checks + 1;
        if (act != expv) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic modelReset();
        pending = 0;
        goodCnt = 0;
        lockedM = 0;
        lastPer = 0;
        lastHi  = 0;
    endtask

    // A completed period of length p with h high samples, reported at cycle c
    task automatic modelMeasure(input int p, input int h, input int c);
        exp_t ev;
        bit good;
        good = (p == DIV) && (h >= HI_MIN) && (h <= HI_MAX);
        if (good) begin
            goodCnt = (goodCnt + 1 > LOCK_CNT) ? LOCK_CNT : goodCnt + 1;
            if (goodCnt == LOCK_CNT) lockedM = 1;
        end else begin
            goodCnt = 0;
            lockedM = 0;
        end
        lastPer = p;
        lastHi  = h;
        ev = '{cyc: c, mv: 1'b1, er: !good, per: p, hi: h, lk: lockedM};
        expQ.push_back(ev);
    endtask

    // A rise driven at cycle e that starts a segment of hi high / lo low cycles
    task automatic modelRise(input int e, input int hi, input int lo);
        exp_t ev;
        if (pending) modelMeasure(pendP, pendH, e + 2);
        if (hi + lo > TMO) begin
            goodCnt = 0;
            lockedM = 0;
            pending = 0;
            ev = '{cyc: e + TMO + 2, mv: 1'b0, er: 1'b1, per: lastPer, hi: lastHi, lk: 1'b0};
            expQ.push_back(ev);
        end else begin
            pending = 1;
            pendP   = hi + lo;
            pendH   = hi;
        end
    endtask

    task automatic applyStimulus(input int hi, input int lo);
        @(negedge clk);
        monIf.clk_div = 1'b1;
        modelRise(cyc, hi, lo);
        repeat (hi - 1) @(negedge clk);
        @(negedge clk);
        monIf.clk_div = 1'b0;
        repeat (lo - 1) @(negedge clk);
    endtask

    task automatic applyRepeat(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) applyStimulus(hi, lo);
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, "_meas_valid"}, int'(monIf.meas_valid), 0);
        checkVal({tag, "_period"}, int'(monIf.period_o), 0);
        checkVal({tag, "_high"}, int'(monIf.high_o), 0);
        checkVal({tag, "_err"}, int'(monIf.err), 0);
        checkVal({tag, "_locked"}, int'(monIf.locked), 0);
    endtask

    // Reset asserted shortly after a rise while locked; the rise's measurement
    // still comes out, then every output must read zero after the reset edge
    task automatic resetMidPeriod();
        @(negedge clk);
        monIf.clk_div = 1'b1;
        if (pending) modelMeasure(pendP, pendH, cyc + 2);
        pending = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_reset");
        monIf.clk_div = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    // Scoreboard monitor: every output event must match the oldest prediction
    always @(negedge clk) begin
        if (monIf.meas_valid || monIf.err) begin
            if (expQ.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("[TB] FAIL unexpected_event: got meas_valid=%0b err=%0b, expected no event (cycle %0d)",
                         monIf.meas_valid, monIf.err, cyc);
            end else begin
                exp_t ev;
                ev = expQ.pop_front();
                checkVal("event_cycle", cyc, ev.cyc);
                checkVal("meas_valid", int'(monIf.meas_valid), int'(ev.mv));
                checkVal("err", int'(monIf.err), int'(ev.er));
                checkVal("period_o", int'(monIf.period_o), ev.per);
                checkVal("high_o", int'(monIf.high_o), ev.hi);
                checkVal("locked", int'(monIf.locked), int'(ev.lk));
            end
        end
    end

    initial begin
        int r, hi, lo;
        rst = 1'b1;
        monIf.clk_div = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("reset");
        rst = 1'b0;

        // Divide-by-9, 4 high / 5 low: arm, then lock after four good periods
        applyRepeat(6, 4, 5);
        // Period 8: every measurement is an error, lock drops and stays low
        applyRepeat(3, 4, 4);
        // Relock, then one period of 10, then relock again
        applyRepeat(5, 4, 5);
        applyStimulus(5, 5);
        applyRepeat(5, 4, 5);
        // Dead clock while locked: single timeout, then re-arm on resumption
        applyStimulus(4, 30);
        applyRepeat(2, 4, 5);
        // Right period, too much high time
        applyStimulus(7, 2);
        applyStimulus(4, 5);
        // Period of exactly 2*DIV: rise and timeout coincide, rise wins
        applyStimulus(9, 9);
        applyRepeat(6, 4, 5);
        // Reset in the middle of a period while locked
        resetMidPeriod();
        applyRepeat(3, 4, 5);

        // Randomized mix of good periods, odd periods and dead gaps
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                hi = $urandom_range(HI_MIN, HI_MAX);
                lo = DIV - hi;
            end else if (r <= 7) begin
                hi = $urandom_range(1, 9);
                lo = $urandom_range(1, 10);
            end else if (r == 8) begin
                hi = $urandom_range(3, 6);
                lo = $urandom_range(14, 18);
            end else begin
                hi = DIV;
                lo = DIV;
            end
            applyStimulus(hi, lo);
        end

        // Close the last period with a dead gap so every prediction comes due
        applyStimulus(4, 25);
        repeat (10) @(negedge clk);
        checkVal("queue_drained", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Checks a divided clock produced by the team's DFF-based dividers, such as the divide-by-9 stage. It samples the divided signal in the source clock domain and measures the period and high time of each cycle in source-clock cycles. It flags any deviation from the expected ratio and asserts `locked` after a run of consecutive good periods. It sits beside the divider as a built-in self-check and as a reusable bench monitor.

## Interface
- `DIV`, 9: expected period of `clk_div`, in `clk` cycles.
- `HI_MIN`, 4: minimum acceptable high time, in cycles.
- `HI_MAX`, 5: maximum acceptable high time, in cycles.
- `LOCK_CNT`, 4: consecutive good periods required to assert `locked`.
- `CW`, 8: counter and output width; must hold 2*`DIV`.
- `clk`  in  1: source clock, the same clock that drives the divider.
- `rst`  in  1: **synchronous, active-high reset.**
- `clk_div`  in  1: divided clock under test, sampled as data on `clk` posedge.
- `meas_valid`  out  1: one-cycle pulse when a period measurement completes.
- `period_o`  out  CW: last measured period, in cycles.
- `high_o`  out  CW: last measured high time, in cycles.
- `err`  out  1: one-cycle pulse on a bad period or a timeout.
- `locked`  out  1: level, high after `LOCK_CNT` consecutive good periods.

## Operation
- Sampling: `s1 <= clk_div`, `s2 <= s1`. Define `rise = s1 & ~s2`.
- `pcnt` (period counter):
  - On `rise`: capture `pcnt` into `period_o`, then load 1.
  - Otherwise: increment, saturating at 2*`DIV`.
- `hcnt` (high counter):
  - On `rise`: capture `hcnt` into `high_o`, then load 1.
  - Otherwise: increment while `s1`=1.
- A period is good when `period_o == DIV` and `HI_MIN <= high_o <= HI_MAX`.
- FSM states: IDLE, MEASURE, LOCKED.
  - IDLE: the first `rise` only arms the counters. No `meas_valid`. Go to MEASURE.
  - MEASURE, on `rise`: pulse `meas_valid`.
    - If good: `good_cnt`++. When `good_cnt` reaches `LOCK_CNT`, go to LOCKED and set `locked`=1.
    - If bad: pulse `err`, clear `good_cnt`, stay in MEASURE.
  - LOCKED, on `rise`: pulse `meas_valid`.
    - If bad: pulse `err`, clear `locked` and `good_cnt`, go to MEASURE.
  - Timeout (MEASURE or LOCKED): `pcnt` reaches 2*`DIV` with no `rise`. Pulse `err` once, clear `locked` and `good_cnt`, go to IDLE, hold `pcnt`.
- `good_cnt` saturates at `LOCK_CNT`.

## Timing
- Reset values: `meas_valid`=0, `period_o`=0, `high_o`=0, `err`=0, `locked`=0, `s1`=`s2`=0, FSM=IDLE, all counters 0.
- Latency:
  - Edge k: `s1` first captures `clk_div`=1, so `rise` is true during cycle k.
  - Edge k+1: `meas_valid`, `period_o`, `high_o`, `err`, `locked` update.
  - Input transition to flag: 2 `clk` edges.
- `period_o` and `high_o` hold between measurements. They are not cleared by errors.
- Simultaneous `rise` and timeout on the same cycle: `rise` takes priority. The measured period is 2*`DIV`, so it is bad: a single `err` pulse, go to MEASURE.
- Reset asserted mid-measurement: all state clears on the next edge. The next `rise` after reset arms only.
- `err` never pulses on two consecutive cycles from the same cause.

## Structure
- Package `clkdiv_pkg`: FSM state enum (IDLE, MEASURE, LOCKED) and a localparam for the timeout multiplier (2).
- Sub-module `clkdiv_edge_det`: the `s1`/`s2` sampler. Outputs `rise` and the sampled level `s1`.
- Top module contains the counters, the FSM and the output registers.

## Test plan
- Divide-by-9 waveform (4 high / 5 low) after reset:
  - No `meas_valid` on the first rise.
  - Then `meas_valid` every 9 cycles with `period_o`=9, `high_o`=4, `err`=0.
  - `locked`=1 one cycle after the 5th rise.
- Period-8 waveform (4 high / 4 low): `err` with each `meas_valid`, `period_o`=8, `locked` stays 0.
- Lock, then inject one period of 10:
  - `err` pulse and `locked`=0 on the edge after that rise.
  - `locked` reasserts after 4 further good periods.
- Lock, then hold `clk_div` low:
  - `err` once when `pcnt` hits 18, `locked`=0, FSM=IDLE.
  - On resumption, the first rise produces no `meas_valid`.
- Good 9-cycle period with 7 high: `high_o`=7, `err` pulses.
- Assert `rst` mid-period while `locked`=1: all outputs are 0 on the next edge.
